dcache_ctrl: RTL and testbench
==============================

Name: dcache_ctrl

Overview:
Parametrised direct-mapped data cache for the pipelined MIPS core, placed between the M stage and main data memory. Write-through, no-write-allocate. Has an internal miss-latency counter, so the core no longer needs an external countdone input. Exports a single stall to the hazard unit and exposes hit/miss statistics counters.

Parameters:
NUM_LINES, 16, number of cache lines; power of two, >=2
WORDS_PER_LINE, 4, 32-bit words per line; power of two, >=2
MISS_CYCLES, 10, main-memory access latency in cycles, >=1

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
memread  input  1  M-stage load request
memwrite  input  1  M-stage store request
addr  input  32  byte address (ALU output, M stage); bits[1:0] ignored
writedata  input  32  store data
readdata  output  32  load data; valid when memread=1 and stall=0
stall  output  1  combinational; holds F/D/E/M stages while 1
mem_addr  output  32  word-aligned address to main memory
mem_wdata  output  32  store data to main memory
mem_we  output  1  one-cycle main-memory write strobe
mem_rdata  input  32  main-memory read data, combinational from mem_addr
hit_count  output  32  completed read hits, wraps at 2^32
miss_count  output  32  read misses, wraps at 2^32

Behaviour:
- Address split: offset = addr[OB+1:2], with OB=log2(WORDS_PER_LINE). index = next log2(NUM_LINES) bits. tag = remaining upper bits.
- Storage: valid bit, tag and data array per line. Hit = valid[index] && tag match. Lookup is combinational in IDLE.
- States: IDLE, WAIT, FILL, WRITE. Internal regs: cnt (down-counter), fill_idx, wdone flag.
- Reset: state=IDLE, all valid bits=0, cnt=0, fill_idx=0, wdone=0, hit_count=0, miss_count=0. Outputs after reset: stall=0 (no request), mem_we=0.
- Reset asserted mid-operation aborts the fill or write. No line becomes valid, and no mem_we is issued in the reset cycle.
- IDLE, no request: stall=0, mem_we=0.
- IDLE, read hit: readdata = line word at offset, stall=0, hit_count increments.
- IDLE, read miss: stall=1, miss_count increments. Next state is WAIT with cnt=MISS_CYCLES-1.
- WAIT: stall=1, cnt decrements each cycle. When cnt==0, next state is FILL with fill_idx=0.
- FILL: stall=1, mem_addr={tag,index,fill_idx,2'b00}. mem_rdata is written into the data word at fill_idx and fill_idx increments. After the last word, set valid and tag, then go to IDLE. The repeated request then hits.
- Read miss cost: 1+MISS_CYCLES+WORDS_PER_LINE stall cycles, then the hit cycle with stall=0.
- IDLE, memwrite with wdone=0: stall=1. Next state is WRITE with cnt=MISS_CYCLES-1.
- WRITE: stall=1, mem_addr={addr[31:2],2'b00}, mem_wdata=writedata. On the cnt==0 cycle:
  - mem_we=1;
  - if the line hits, update the cached word;
  - set wdone=1 and go to IDLE.
- IDLE with wdone=1: stall=0 for exactly one cycle so the store retires, then wdone clears. Write cost: 1+MISS_CYCLES stall cycles.
- Store miss does not allocate a line and leaves valid unchanged.
- memread and memwrite both 1: treated as a write.
- Request inputs are sampled only in IDLE. The core holds them stable while stall=1.
- Statistics counters increment only in IDLE on the qualifying cycle. They wrap silently.

Decomposition:
- Shared package: state encoding localparams (IDLE/WAIT/FILL/WRITE) and address-split width functions (clog2-based OB, IB, TB).
- One sub-module, dcache_array, holds the valid/tag/data storage. It has a combinational read port and one synchronous word-write port plus a line-validate strobe.
- The FSM, counters and statistics stay in dcache_ctrl.

Test Plan:
- Reset then read 0x100 (default params) -> stall=1 for 15 cycles. mem_addr steps 0x100,0x104,0x108,0x10C during FILL. Next cycle stall=0, readdata=mem[0x100]. miss_count=1, hit_count=1.
- Read 0x104 after the above -> stall=0 the same cycle, readdata=mem[0x104], hit_count=2.
- Store 0xDEADBEEF to 0x108 (line resident) -> 11 stall cycles, then one mem_we pulse at 0x108. Next cycle stall=0. A later read of 0x108 hits and returns 0xDEADBEEF.
- Store to 0x400 (miss, same index as 0x000) -> mem_we issued, no allocation. A following read of 0x400 misses and miss_count increments.
- Conflict: read 0x100, read 0x200 (same index for 16x4), read 0x100 -> three misses, miss_count=3.
- Reset asserted in FILL cycle 2 -> no mem_we, stall=0 next cycle, line invalid. Re-read misses.

Source files
------------

// File: rtl/dcache_pkg.sv
// Shared definitions for the direct-mapped write-through data cache:
// controller state encoding and address-split width helpers.
package dcache_pkg;

    // Controller states
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_FILL  = 2'd2,
        S_WRITE = 2'd3
    } state_t;

    localparam int ADDR_W         = 32;
    localparam int WORD_BYTE_BITS = 2;

    // Word-offset field width inside a line
    function automatic int offset_bits(input int words_per_line);
        return $clog2(words_per_line);
    endfunction

    // Line-index field width
    function automatic int index_bits(input int num_lines);
        return $clog2(num_lines);
    endfunction

    // Tag width: everything above index and offset
    function automatic int tag_bits(input int words_per_line, input int num_lines);
        return ADDR_W - WORD_BYTE_BITS - $clog2(words_per_line) - $clog2(num_lines);
    endfunction

endpackage

// File: rtl/dcache_array.sv
// Valid/tag/data storage for the direct-mapped cache.
// Combinational read port; one synchronous word-write port and a
// line-validate strobe that share the write index.
module dcache_array
    import dcache_pkg::*;
#(
    parameter int NUM_LINES = 16,
    parameter int IDX_W     = 4,
    parameter int OFF_W     = 2,
    parameter int TAG_W     = 24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [IDX_W-1:0] rindex,
    input  logic [OFF_W-1:0] roff,
    output logic             rvalid,
    output logic [TAG_W-1:0] rtag,
    output logic [31:0]      rdata,
    input  logic             we,
    input  logic [IDX_W-1:0] windex,
    input  logic [OFF_W-1:0] woff,
    input  logic [31:0]      wdata,
    input  logic             validate,
    input  logic [TAG_W-1:0] vtag
);

    localparam int DEPTH = NUM_LINES << OFF_W;

    logic [NUM_LINES-1:0] valid_q;
    logic [TAG_W-1:0]     tag_q  [NUM_LINES];
    logic [31:0]          data_q [DEPTH];

    // Valid bits: cleared by reset, set when a fill completes
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
        end else if (validate) begin
            valid_q[windex] <= 1'b1;
        end
    end

    // Tag captured together with the validate strobe
    always_ff @(posedge clk) begin
        if (validate) begin
            tag_q[windex] <= vtag;
        end
    end

    // Word write (fill data or store hit)
    always_ff @(posedge clk) begin
        if (we) begin
            data_q[{windex, woff}] <= wdata;
        end
    end

    // Combinational lookup
    always_comb begin
        rvalid = valid_q[rindex];
        rtag   = tag_q[rindex];
        rdata  = data_q[{rindex, roff}];
    end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache controller
// sitting between the M stage and main memory. Misses and stores are
// timed by an internal latency counter; one combinational stall goes to
// the hazard unit. Read hit/miss statistics are exported.
//
// Handshake: memread/memwrite are requests sampled only in IDLE; the core
// holds addr/writedata/requests stable while stall=1. A load completes in
// the cycle stall=0 with readdata valid; a store completes in the single
// stall=0 cycle that follows the memory write strobe.
module dcache_ctrl
    import dcache_pkg::*;
#(
    parameter int NUM_LINES      = 16,
    parameter int WORDS_PER_LINE = 4,
    parameter int MISS_CYCLES    = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memread,
    input  logic        memwrite,
    input  logic [31:0] addr,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        stall,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    input  logic [31:0] mem_rdata,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
);

    localparam int OB = offset_bits(WORDS_PER_LINE);
    localparam int IB = index_bits(NUM_LINES);
    localparam int TB = tag_bits(WORDS_PER_LINE, NUM_LINES);
    localparam int CW = $clog2(MISS_CYCLES + 1);

    localparam logic [CW-1:0] CNT_INIT  = CW'(MISS_CYCLES - 1);
    localparam logic [OB-1:0] LAST_WORD = OB'(WORDS_PER_LINE - 1);

    state_t        state;
    logic [CW-1:0] cnt;
    logic [OB-1:0] fill_idx;
    logic          wdone;

    logic [OB-1:0] addr_off;
    logic [IB-1:0] addr_idx;
    logic [TB-1:0] addr_tag;
    logic          addr_unused;

    logic          arr_valid;
    logic [TB-1:0] arr_tag;
    logic [31:0]   arr_rdata;
    logic          arr_we;
    logic [OB-1:0] arr_woff;
    logic [31:0]   arr_wdata;
    logic          arr_validate;
    logic          hit;
    logic          write_last;

    assign addr_off    = addr[OB+1:2];
    assign addr_idx    = addr[OB+IB+1:OB+2];
    assign addr_tag    = addr[31:OB+IB+2];
    assign addr_unused = ^addr[1:0];

    assign hit        = arr_valid && (arr_tag == addr_tag);
    assign write_last = (state == S_WRITE) && (cnt == '0);

    dcache_array #(
        .NUM_LINES (NUM_LINES),
        .IDX_W     (IB),
        .OFF_W     (OB),
        .TAG_W     (TB)
    ) u_array (
        .clk      (clk),
        .reset    (reset),
        .rindex   (addr_idx),
        .roff     (addr_off),
        .rvalid   (arr_valid),
        .rtag     (arr_tag),
        .rdata    (arr_rdata),
        .we       (arr_we),
        .windex   (addr_idx),
        .woff     (arr_woff),
        .wdata    (arr_wdata),
        .validate (arr_validate),
        .vtag     (addr_tag)
    );

    // Array write controls; suppressed in a reset cycle so an aborted
    // fill or store leaves nothing behind
    always_comb begin
        arr_we       = 1'b0;
        arr_woff     = addr_off;
        arr_wdata    = writedata;
        arr_validate = 1'b0;
        if (!reset) begin
            if (state == S_FILL) begin
                arr_we       = 1'b1;
                arr_woff     = fill_idx;
                arr_wdata    = mem_rdata;
                arr_validate = (fill_idx == LAST_WORD);
            end else if (write_last && hit) begin
                arr_we = 1'b1;
            end
        end
    end

    // Memory-side outputs: line-fill address in FILL, word address otherwise
    always_comb begin
        mem_wdata = writedata;
        mem_we    = write_last && !reset;
        if (state == S_FILL) begin
            mem_addr = {addr_tag, addr_idx, fill_idx, 2'b00};
        end else begin
            mem_addr = {addr[31:2], 2'b00};
        end
    end

    // Stall to the hazard unit and load data
    always_comb begin
        readdata = arr_rdata;
        stall    = 1'b1;
        if (state == S_IDLE) begin
            if (wdone) begin
                stall = 1'b0;
            end else if (memwrite) begin
                stall = 1'b1;
            end else if (memread) begin
                stall = !hit;
            end else begin
                stall = 1'b0;
            end
        end
    end

    // Controller FSM, latency counter and statistics
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            cnt        <= '0;
            fill_idx   <= '0;
            wdone      <= 1'b0;
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (wdone) begin
                        wdone <= 1'b0;
                    end else if (memwrite) begin
                        state <= S_WRITE;
                        cnt   <= CNT_INIT;
                    end else if (memread) begin
                        if (hit) begin
                            hit_count <= hit_count + 32'd1;
                        end else begin
                            miss_count <= miss_count + 32'd1;
                            state      <= S_WAIT;
                            cnt        <= CNT_INIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (cnt == '0) begin
                        state    <= S_FILL;
                        fill_idx <= '0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_FILL: begin
                    fill_idx <= fill_idx + 1'b1;
                    if (fill_idx == LAST_WORD) begin
                        state <= S_IDLE;
                    end
                end
                S_WRITE: begin
                    if (cnt == '0) begin
                        wdone <= 1'b1;
                        state <= S_IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Bench for dcache_ctrl: directed scenarios followed by randomized
// loads/stores, checked against a line-residency model of the cache and
// a word-level model of main memory.
module tb_dcache_ctrl;

    localparam int NL  = 16;
    localparam int WPL = 4;
    localparam int MC  = 10;
    localparam int MEM_WORDS = 4096;

    logic        clk = 1'b0;
    logic        reset;
    logic        memread;
    logic        memwrite;
    logic [31:0] addr;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        stall;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic [31:0] mem_rdata;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    int checks = 0;
    int errors = 0;

    // Environment main memory (driven by the DUT's strobe)
    logic [31:0] env_mem [MEM_WORDS];
    // Reference model: expected memory contents and resident lines
    logic [31:0] ref_mem [MEM_WORDS];
    bit          ref_v    [NL];
    int unsigned ref_line [NL];
    int unsigned exp_hits;
    int unsigned exp_misses;

    dcache_ctrl #(
        .NUM_LINES      (NL),
        .WORDS_PER_LINE (WPL),
        .MISS_CYCLES    (MC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .memread    (memread),
        .memwrite   (memwrite),
        .addr       (addr),
        .writedata  (writedata),
        .readdata   (readdata),
        .stall      (stall),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_we     (mem_we),
        .mem_rdata  (mem_rdata),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    // Clock
    always #5 clk = ~clk;

    // Main memory: combinational read, write on strobe
    always_comb mem_rdata = env_mem[mem_addr[13:2]];

    always @(posedge clk) begin
        if (mem_we) env_mem[mem_addr[13:2]] <= mem_wdata;
    end

    // Watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int unsigned line_of(input logic [31:0] a);
        return a / (4 * WPL);
    endfunction

    function automatic int unsigned index_of(input logic [31:0] a);
        return line_of(a) % NL;
    endfunction

    function automatic bit resident(input logic [31:0] a);
        return ref_v[index_of(a)] && (ref_line[index_of(a)] == line_of(a));
    endfunction

    task automatic ref_reset();
        for (int i = 0; i < NL; i++) begin
            ref_v[i]    = 1'b0;
            ref_line[i] = 0;
        end
        exp_hits   = 0;
        exp_misses = 0;
    endtask

    task automatic check_counters(input string tag);
        check({tag, "_hits"}, hit_count, exp_hits);
        check({tag, "_misses"}, miss_count, exp_misses);
    endtask

    // Load: called just after a rising edge; returns just after the retiring edge
    task automatic do_read(input logic [31:0] a);
        int s;
        int exp_stalls;
        logic [31:0] base;
        bit was_res;
        was_res    = resident(a);
        exp_stalls = was_res ? 0 : (1 + MC + WPL);
        base       = line_of(a) * (4 * WPL);
        memread  = 1'b1;
        memwrite = 1'b0;
        addr     = a;
        s = 0;
        while (1) begin
            @(negedge clk);
            check("read_no_we", {31'd0, mem_we}, 32'd0);
            if (!stall) break;
            if (s >= 1 + MC && s < 1 + MC + WPL)
                check("fill_addr", mem_addr, base + 32'(4 * (s - 1 - MC)));
            s++;
            if (s > 100) begin
                check("read_timeout", 32'(s), 32'(exp_stalls));
                break;
            end
            @(posedge clk); #1;
        end
        check("read_stalls", 32'(s), 32'(exp_stalls));
        check("readdata", readdata, ref_mem[a[13:2]]);
        if (!was_res) begin
            exp_misses++;
            ref_v[index_of(a)]    = 1'b1;
            ref_line[index_of(a)] = line_of(a);
        end
        exp_hits++;
        @(posedge clk); #1;
        memread = 1'b0;
        check_counters("read");
    endtask

    // Store (optionally with memread also raised)
    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input bit both);
        int s;
        int we_seen;
        memread   = both;
        memwrite  = 1'b1;
        addr      = a;
        writedata = d;
        s = 0;
        we_seen = 0;
        while (1) begin
            @(negedge clk);
            if (mem_we) begin
                we_seen++;
                check("we_cycle", 32'(s), 32'(MC));
                check("we_addr", mem_addr, {a[31:2], 2'b00});
                check("we_data", mem_wdata, d);
            end
            if (!stall) break;
            s++;
            if (s > 100) begin
                check("write_timeout", 32'(s), 32'(1 + MC));
                break;
            end
            @(posedge clk); #1;
        end
        check("write_stalls", 32'(s), 32'(1 + MC));
        check("write_pulses", 32'(we_seen), 32'd1);
        ref_mem[a[13:2]] = d;
        @(posedge clk); #1;
        memread  = 1'b0;
        memwrite = 1'b0;
        check_counters("write");
    endtask

    initial begin
        int s;
        logic [31:0] ra;
        logic [31:0] rd;
        int op;

        for (int i = 0; i < MEM_WORDS; i++) begin
            env_mem[i] = 32'(i) * 32'h9E3779B1 + 32'h0000_1234;
            ref_mem[i] = 32'(i) * 32'h9E3779B1 + 32'h0000_1234;
        end
        ref_reset();

        // Reset
        reset     = 1'b1;
        memread   = 1'b0;
        memwrite  = 1'b0;
        addr      = '0;
        writedata = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_stall", {31'd0, stall}, 32'd0);
        check("rst_mem_we", {31'd0, mem_we}, 32'd0);
        check_counters("rst");
        @(posedge clk); #1;

        // Cold miss then hit on same line
        do_read(32'h100);
        do_read(32'h104);

        // Store hit, then read it back
        do_write(32'h108, 32'hDEADBEEF, 1'b0);
        do_read(32'h108);

        // Store miss to same index as resident 0x100: no allocation, no corruption
        do_write(32'h400, 32'h0BADF00D, 1'b0);
        do_read(32'h100);
        do_read(32'h400);

        // Conflict misses at index 0
        do_read(32'h100);
        do_read(32'h200);
        do_read(32'h100);

        // Simultaneous read+write request is a store
        do_write(32'h10C, 32'h12345678, 1'b1);
        do_read(32'h10C);

        // Reset in the second fill cycle
        memread = 1'b1;
        addr    = 32'h500;
        repeat (1 + MC + 1) begin
            @(posedge clk); #1;
        end
        reset   = 1'b1;
        @(negedge clk);
        check("abort_mem_we", {31'd0, mem_we}, 32'd0);
        check("abort_fill_addr", mem_addr, 32'h504);
        @(posedge clk); #1;
        reset   = 1'b0;
        memread = 1'b0;
        ref_reset();
        @(negedge clk);
        check("abort_stall", {31'd0, stall}, 32'd0);
        check("abort_mem_we2", {31'd0, mem_we}, 32'd0);
        check_counters("abort");
        @(posedge clk); #1;
        do_read(32'h500);
        do_read(32'h100);

        // Randomized loads and stores
        for (int n = 0; n < 60; n++) begin
            ra = 32'($urandom_range(0, 7) * 256 + $urandom_range(0, 63) * 4);
            op = $urandom_range(0, 9);
            if (op < 6) begin
                do_read(ra);
            end else begin
                rd = $urandom;
                do_write(ra, rd, op == 9);
            end
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
